adrv9001_enable_seq: RTL and testbench
======================================

ADRV9001_ENABLE_SEQ -- requirements
Module: adrv9001_enable_seq

Interface
REQ-001 SHALL have parameter DELAY_WIDTH, default 16, meaning bit width of the delay inputs and of the internal delay counter.
REQ-002 SHALL have port clk  input  1  the single clock for all logic.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port enable_mode  input  1  request source select: 0 = ps_enable, 1 = ext_enable.
REQ-005 SHALL have port ps_enable  input  1  software enable request, level-sensitive.
REQ-006 SHALL have port ext_enable  input  1  external or pin trigger enable request, level-sensitive, already synchronous to clk.
REQ-007 SHALL have port enable_delay  input  DELAY_WIDTH  cycles from en_pin rise to dp_enable rise, minus one.
REQ-008 SHALL have port disable_delay  input  DELAY_WIDTH  cycles from dp_enable fall to en_pin fall, minus one.
REQ-009 SHALL have port en_pin  output  1  registered drive to the ADRV9001 TX/RX enable pin.
REQ-010 SHALL have port dp_enable  output  1  registered datapath enable (gates TX data source / RX data capture).
REQ-011 SHALL have port state  output  2  current FSM state: 0 IDLE, 1 EN_DLY, 2 ACTIVE, 3 DIS_DLY.
REQ-012 SHALL have port burst_count  output  32  number of completed enable bursts.

Function
REQ-013 SHALL form req = enable_mode ? ext_enable : ps_enable, sampled every clk edge; there is no other request qualification.
REQ-014 IDLE: when req=1, SHALL go to EN_DLY, load counter with enable_delay, and set en_pin=1 on the same edge; when req=0, SHALL stay in IDLE.
REQ-015 EN_DLY: when req=1 and counter=0, SHALL go to ACTIVE and set dp_enable=1; when req=1 and counter!=0, SHALL decrement the counter.
REQ-016 EN_DLY: when req=0, SHALL abort to DIS_DLY, load counter with disable_delay, and keep dp_enable=0.
REQ-017 ACTIVE: when req=0, SHALL go to DIS_DLY, load counter with disable_delay, and clear dp_enable on the same edge; en_pin SHALL stay 1.
REQ-018 DIS_DLY: when counter=0, SHALL go to IDLE and clear en_pin; otherwise SHALL decrement the counter.
REQ-019 DIS_DLY SHALL always complete regardless of req; req=1 during DIS_DLY SHALL be honoured only after IDLE is reached, with at least one IDLE cycle and en_pin low for at least one cycle.
REQ-020 Net latency: dp_enable rise SHALL occur exactly enable_delay+1 cycles after en_pin rise, and en_pin fall exactly disable_delay+1 cycles after dp_enable fall; delay 0 gives 1 cycle.
REQ-021 enable_delay/disable_delay SHALL be sampled only at counter load; changes mid-delay SHALL have no effect on the current delay.
REQ-022 Changing enable_mode mid-burst SHALL simply switch the req source; the resulting req value is handled per REQ-014..019 with no extra state.
REQ-023 dp_enable=1 SHALL imply en_pin=1 on every cycle.

Reset
REQ-024 On rst=1 at a clk edge: state=IDLE, en_pin=0, dp_enable=0, counter=0, burst_count=0; this applies in every state, including mid-delay (en_pin drops immediately, no disable delay).
REQ-025 First request evaluation SHALL be on the first edge with rst=0.

Configuration
REQ-026 Macro ADRV9001_ENABLE_SEQ_CNT_EN defined: burst_count SHALL increment by 1 on each ACTIVE->DIS_DLY transition, saturating at 32'hFFFFFFFF; EN_DLY aborts SHALL not count.
REQ-027 Macro undefined: burst_count SHALL be constant 0 and no counter logic synthesised.

Verification
REQ-028 enable_mode=0, enable_delay=3, disable_delay=5, ps_enable 0->1 at cycle 10, 1->0 at cycle 30 -> en_pin rises cycle 11, dp_enable rises cycle 15, dp_enable falls 31, en_pin falls 37; burst_count=1 (macro defined).
REQ-029 Both delays 0, ext_enable pulse one cycle with enable_mode=1 -> en_pin 1 for two cycles, dp_enable never rises (abort from EN_DLY), burst_count unchanged.
REQ-030 ps_enable reasserted at second cycle of DIS_DLY with disable_delay=4 -> en_pin falls on schedule, stays low exactly one cycle, then re-rises; dp_enable rises enable_delay+1 cycles later.
REQ-031 rst pulsed during ACTIVE with en_pin=1, dp_enable=1 -> both 0 and state=0 on the next edge; burst_count=0.
REQ-032 enable_delay changed 3->100 during EN_DLY -> dp_enable still rises 4 cycles after en_pin; next burst uses 100.
REQ-033 Build without ADRV9001_ENABLE_SEQ_CNT_EN, run REQ-028 stimulus -> identical en_pin/dp_enable timing, burst_count constant 0.

Source files
------------

// File: rtl/adrv9001_enable_seq_if.sv
// Request/status bundle for the ADRV9001 enable sequencer.
// master: request side (software/pin logic), slave: the sequencer itself.
interface adrv9001_enable_seq_if #(
  parameter int DELAY_WIDTH = 16
);
  logic                   enable_mode;
  logic                   ps_enable;
  logic                   ext_enable;
  logic [DELAY_WIDTH-1:0] enable_delay;
  logic [DELAY_WIDTH-1:0] disable_delay;
  logic                   en_pin;
  logic                   dp_enable;
  logic [1:0]             state;
  logic [31:0]            burst_count;

  modport master (
    output enable_mode, ps_enable, ext_enable, enable_delay, disable_delay,
    input  en_pin, dp_enable, state, burst_count
  );

  modport slave (
    input  enable_mode, ps_enable, ext_enable, enable_delay, disable_delay,
    output en_pin, dp_enable, state, burst_count
  );
endinterface

// File: rtl/adrv9001_enable_seq.sv
// ADRV9001 TX/RX enable sequencer.
// Raises the chip enable pin, waits enable_delay+1 cycles, then opens the
// datapath; on release closes the datapath first and drops the pin
// disable_delay+1 cycles later.
// Optional feature: define ADRV9001_ENABLE_SEQ_CNT_EN to build the
// saturating completed-burst counter; otherwise burst_count is tied to 0.
//
// state   | meaning
// IDLE    | pin low, datapath off, waiting for req
// EN_DLY  | pin high, counting down enable delay, datapath off
// ACTIVE  | pin high, datapath on
// DIS_DLY | datapath off, counting down disable delay, pin still high
module adrv9001_enable_seq #(
  parameter int DELAY_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  adrv9001_enable_seq_if.slave sq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EN_DLY  = 2'd1,
    S_ACTIVE  = 2'd2,
    S_DIS_DLY = 2'd3
  } state_e;

  state_e                 state_q;
  logic [DELAY_WIDTH-1:0] cnt_q;
  logic                   en_pin_q;
  logic                   dp_enable_q;
  logic                   req;

  // Request source mux; no further qualification of the request.
  assign req = sq.enable_mode ? sq.ext_enable : sq.ps_enable;

  // Sequencer FSM with registered pin/datapath outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      en_pin_q    <= 1'b0;
      dp_enable_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q  <= S_EN_DLY;
            cnt_q    <= sq.enable_delay;
            en_pin_q <= 1'b1;
          end
        end
        S_EN_DLY: begin
          if (!req) begin
            // Abort before the datapath ever opened; pin still needs its
            // full disable delay.
            state_q <= S_DIS_DLY;
            cnt_q   <= sq.disable_delay;
          end else if (cnt_q == '0) begin
            state_q     <= S_ACTIVE;
            dp_enable_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ACTIVE: begin
          if (!req) begin
            state_q     <= S_DIS_DLY;
            cnt_q       <= sq.disable_delay;
            dp_enable_q <= 1'b0;
          end
        end
        S_DIS_DLY: begin
          // Runs to completion regardless of req; a new request is only
          // seen from IDLE, guaranteeing at least one pin-low cycle.
          if (cnt_q == '0) begin
            state_q  <= S_IDLE;
            en_pin_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          en_pin_q    <= 1'b0;
          dp_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign sq.en_pin    = en_pin_q;
  assign sq.dp_enable = dp_enable_q;
  assign sq.state     = state_q;

`ifdef ADRV9001_ENABLE_SEQ_CNT_EN
  logic [31:0] burst_cnt_q;
  logic [31:0] burst_cnt_d;

  // Count completed bursts (ACTIVE release), saturating at all-ones.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == S_ACTIVE && !req && burst_cnt_q != 32'hFFFF_FFFF) begin
      burst_cnt_d = burst_cnt_q + 32'd1;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign sq.burst_count = burst_cnt_q;
`else
  assign sq.burst_count = 32'd0;
`endif

endmodule

// File: tb/tb_adrv9001_enable_seq.sv
// Self-checking bench for adrv9001_enable_seq: directed timing scenarios
// plus randomized request/delay traffic against an elapsed-time model.
module tb_adrv9001_enable_seq;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;

  adrv9001_enable_seq_if #(.DELAY_WIDTH(DW)) sq ();

  adrv9001_enable_seq #(.DELAY_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (sq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: pin on/off, datapath on/off, edges elapsed since the
  // pin rose or since shutdown began, and the delays latched at those times.
  bit          m_en, m_dp, m_shut;
  int          m_k, m_s, m_edl, m_ddl;
  logic [31:0] m_burst;

  // Observed transition edge numbers and per-test activity counters.
  int  t_en_rise, t_en_fall, t_dp_rise, t_dp_fall;
  int  en_hi_cycles, dp_hi_cycles;
  logic prev_en, prev_dp;

  task automatic model_step();
    bit req;
    req = sq.enable_mode ? sq.ext_enable : sq.ps_enable;
    if (rst) begin
      m_en = 0; m_dp = 0; m_shut = 0; m_burst = '0;
      return;
    end
    if (!m_en) begin
      if (req) begin
        m_en = 1; m_k = 0; m_edl = int'(sq.enable_delay);
      end
    end else if (m_shut) begin
      m_s++;
      if (m_s == m_ddl + 1) begin
        m_en = 0; m_shut = 0;
      end
    end else if (m_dp) begin
      if (!req) begin
        m_dp = 0; m_shut = 1; m_s = 0; m_ddl = int'(sq.disable_delay);
        if (m_burst != 32'hFFFF_FFFF) m_burst = m_burst + 32'd1;
      end
    end else begin
      m_k++;
      if (!req) begin
        m_shut = 1; m_s = 0; m_ddl = int'(sq.disable_delay);
      end else if (m_k == m_edl + 1) begin
        m_dp = 1;
      end
    end
  endtask

  // One clock: advance model, compare DUT against it, log transitions.
  task automatic tick();
    logic [1:0]  exp_state;
    logic [31:0] exp_burst;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    exp_state = !m_en ? 2'd0 : (m_shut ? 2'd3 : (m_dp ? 2'd2 : 2'd1));
`ifdef ADRV9001_ENABLE_SEQ_CNT_EN
    exp_burst = m_burst;
`else
    exp_burst = 32'd0;
`endif
    checks++;
    if (sq.en_pin !== m_en) begin
      failures++;
      $display("FAIL en_pin cyc=%0d got=%b exp=%b", cyc, sq.en_pin, m_en);
    end
    checks++;
    if (sq.dp_enable !== m_dp) begin
      failures++;
      $display("FAIL dp_enable cyc=%0d got=%b exp=%b", cyc, sq.dp_enable, m_dp);
    end
    checks++;
    if (sq.state !== exp_state) begin
      failures++;
      $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, sq.state, exp_state);
    end
    checks++;
    if (sq.burst_count !== exp_burst) begin
      failures++;
      $display("FAIL burst_count cyc=%0d got=%0d exp=%0d", cyc, sq.burst_count, exp_burst);
    end
    checks++;
    if (sq.dp_enable === 1'b1 && sq.en_pin !== 1'b1) begin
      failures++;
      $display("FAIL dp_implies_en cyc=%0d en_pin=%b dp=%b", cyc, sq.en_pin, sq.dp_enable);
    end
    if (sq.en_pin === 1'b1 && prev_en !== 1'b1) t_en_rise = cyc;
    if (sq.en_pin !== 1'b1 && prev_en === 1'b1) t_en_fall = cyc;
    if (sq.dp_enable === 1'b1 && prev_dp !== 1'b1) t_dp_rise = cyc;
    if (sq.dp_enable !== 1'b1 && prev_dp === 1'b1) t_dp_fall = cyc;
    if (sq.en_pin === 1'b1) en_hi_cycles++;
    if (sq.dp_enable === 1'b1) dp_hi_cycles++;
    prev_en = sq.en_pin;
    prev_dp = sq.dp_enable;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_marks();
    t_en_rise = -1; t_en_fall = -1; t_dp_rise = -1; t_dp_fall = -1;
    en_hi_cycles = 0; dp_hi_cycles = 0;
  endtask

  task automatic do_reset();
    sq.ps_enable = 0; sq.ext_enable = 0; sq.enable_mode = 0;
    rst = 1;
    ticks(2);
    rst = 0;
    clear_marks();
  endtask

  task automatic test_reset();
    sq.enable_mode = 0; sq.ps_enable = 1; sq.ext_enable = 1;
    sq.enable_delay = 16'd2; sq.disable_delay = 16'd2;
    rst = 1;
    ticks(3);
    checks++;
    if (sq.en_pin !== 1'b0 || sq.dp_enable !== 1'b0 || sq.state !== 2'd0 || sq.burst_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_state en=%b dp=%b state=%0d burst=%0d exp all 0",
               sq.en_pin, sq.dp_enable, sq.state, sq.burst_count);
    end
    rst = 0;
    tick();
    checks++;
    if (sq.en_pin !== 1'b1) begin
      failures++;
      $display("FAIL first_edge_after_reset en_pin got=%b exp=1", sq.en_pin);
    end
    sq.ps_enable = 0;
    ticks(6);
  endtask

  task automatic test_basic_burst();
    int e1, e2;
    do_reset();
    sq.enable_delay = 16'd3; sq.disable_delay = 16'd5;
    ticks(8);
    sq.ps_enable = 1;
    tick(); e1 = cyc;
    ticks(19);
    sq.ps_enable = 0;
    tick(); e2 = cyc;
    ticks(9);
    checks++;
    if (t_en_rise != e1) begin
      failures++; $display("FAIL basic_en_rise got=%0d exp=%0d", t_en_rise, e1);
    end
    checks++;
    if (t_dp_rise != e1 + 4) begin
      failures++; $display("FAIL basic_dp_rise got=%0d exp=%0d", t_dp_rise, e1 + 4);
    end
    checks++;
    if (t_dp_fall != e2) begin
      failures++; $display("FAIL basic_dp_fall got=%0d exp=%0d", t_dp_fall, e2);
    end
    checks++;
    if (t_en_fall != e2 + 6) begin
      failures++; $display("FAIL basic_en_fall got=%0d exp=%0d", t_en_fall, e2 + 6);
    end
    checks++;
`ifdef ADRV9001_ENABLE_SEQ_CNT_EN
    if (sq.burst_count !== 32'd1) begin
      failures++; $display("FAIL basic_burst_count got=%0d exp=1", sq.burst_count);
    end
`else
    if (sq.burst_count !== 32'd0) begin
      failures++; $display("FAIL basic_burst_count got=%0d exp=0", sq.burst_count);
    end
`endif
  endtask

  task automatic test_abort();
    do_reset();
    sq.enable_delay = 16'd0; sq.disable_delay = 16'd0;
    sq.enable_mode = 1;
    ticks(2);
    sq.ext_enable = 1;
    tick();
    sq.ext_enable = 0;
    ticks(5);
    checks++;
    if (en_hi_cycles != 2) begin
      failures++; $display("FAIL abort_en_cycles got=%0d exp=2", en_hi_cycles);
    end
    checks++;
    if (dp_hi_cycles != 0) begin
      failures++; $display("FAIL abort_dp_cycles got=%0d exp=0", dp_hi_cycles);
    end
  endtask

  task automatic test_back_to_back();
    int e2;
    do_reset();
    sq.enable_delay = 16'd2; sq.disable_delay = 16'd4;
    sq.ps_enable = 1;
    ticks(6);
    sq.ps_enable = 0;
    tick(); e2 = cyc;
    tick();
    sq.ps_enable = 1;
    clear_marks();
    ticks(12);
    checks++;
    if (t_en_fall != e2 + 5) begin
      failures++; $display("FAIL b2b_en_fall got=%0d exp=%0d", t_en_fall, e2 + 5);
    end
    checks++;
    if (t_en_rise != e2 + 6) begin
      failures++; $display("FAIL b2b_en_rerise got=%0d exp=%0d", t_en_rise, e2 + 6);
    end
    checks++;
    if (t_dp_rise != e2 + 9) begin
      failures++; $display("FAIL b2b_dp_rise got=%0d exp=%0d", t_dp_rise, e2 + 9);
    end
    sq.ps_enable = 0;
    ticks(8);
  endtask

  task automatic test_reset_active();
    do_reset();
    sq.enable_delay = 16'd1; sq.disable_delay = 16'd3;
    sq.ps_enable = 1;
    ticks(5);
    rst = 1;
    tick();
    checks++;
    if (sq.en_pin !== 1'b0 || sq.dp_enable !== 1'b0 || sq.state !== 2'd0 || sq.burst_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_in_active en=%b dp=%b state=%0d burst=%0d exp all 0",
               sq.en_pin, sq.dp_enable, sq.state, sq.burst_count);
    end
    rst = 0;
    sq.ps_enable = 0;
    ticks(3);
  endtask

  task automatic test_delay_change();
    int e1, e3;
    do_reset();
    sq.enable_delay = 16'd3; sq.disable_delay = 16'd1;
    sq.ps_enable = 1;
    tick(); e1 = cyc;
    sq.enable_delay = 16'd100;
    ticks(6);
    checks++;
    if (t_dp_rise != e1 + 4) begin
      failures++; $display("FAIL delay_change_dp_rise got=%0d exp=%0d", t_dp_rise, e1 + 4);
    end
    sq.ps_enable = 0;
    ticks(4);
    sq.ps_enable = 1;
    tick(); e3 = cyc;
    ticks(102);
    checks++;
    if (t_dp_rise != e3 + 101) begin
      failures++; $display("FAIL delay_change_next_burst got=%0d exp=%0d", t_dp_rise, e3 + 101);
    end
    sq.ps_enable = 0;
    ticks(4);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0)   sq.ps_enable   = ~sq.ps_enable;
      if ($urandom_range(7) == 0)   sq.ext_enable  = ~sq.ext_enable;
      if ($urandom_range(31) == 0)  sq.enable_mode = ~sq.enable_mode;
      if ($urandom_range(15) == 0)  sq.enable_delay  = 16'($urandom_range(7));
      if ($urandom_range(15) == 0)  sq.disable_delay = 16'($urandom_range(7));
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    sq.enable_mode = 0; sq.ps_enable = 0; sq.ext_enable = 0;
    sq.enable_delay = '0; sq.disable_delay = '0;
    prev_en = 0; prev_dp = 0;
    m_en = 0; m_dp = 0; m_shut = 0; m_k = 0; m_s = 0; m_edl = 0; m_ddl = 0;
    m_burst = '0;
    clear_marks();
    test_reset();
    test_basic_burst();
    test_abort();
    test_back_to_back();
    test_reset_active();
    test_delay_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
